// File: rtl/sm_hw_stack_pkg.sv
// rtl/sm_hw_stack_pkg.sv - shared constants, opcode and action encodings for the hardware stack
package sm_hw_stack_pkg;

  localparam int SM_STACK_DATA_W = 32;
  localparam int SM_STACK_DEPTH  = 32;
  localparam int SM_STACK_PTR_W  = 5;

  // Empty stack: sp parks on the highest slot, the stack grows downward.
  localparam logic [SM_STACK_PTR_W-1:0] SM_STACK_SP_RST = 5'b11111;

  // Opcode as seen by the core's decoder: {pop, push}.
  typedef enum logic [1:0] {
    STK_OP_NONE    = 2'b00,
    STK_OP_PUSH    = 2'b01,
    STK_OP_POP     = 2'b10,
    STK_OP_REPLACE = 2'b11
  } stk_op_e;

  // Resolved action once full/empty are known; exactly one per edge.
  typedef enum logic [2:0] {
    STK_ACT_HOLD = 3'd0,
    STK_ACT_PUSH = 3'd1,
    STK_ACT_POP  = 3'd2,
    STK_ACT_REPL = 3'd3,
    STK_ACT_OVF  = 3'd4,
    STK_ACT_UNF  = 3'd5
  } stk_act_e;

  function automatic stk_op_e stk_decode(input logic push, input logic pop);
    return stk_op_e'({pop, push});
  endfunction

  // Push+pop on an empty stack degrades to a plain push; push+pop on a
  // full stack is a replace and never an overflow.
  function automatic stk_act_e stk_resolve(input stk_op_e op, input logic full,
                                           input logic empty);
    stk_act_e act;
    act = STK_ACT_HOLD;
    case (op)
      STK_OP_PUSH:    act = full  ? STK_ACT_OVF : STK_ACT_PUSH;
      STK_OP_POP:     act = empty ? STK_ACT_UNF : STK_ACT_POP;
      STK_OP_REPLACE: act = empty ? STK_ACT_PUSH : STK_ACT_REPL;
      default:        act = STK_ACT_HOLD;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/sm_stack_ptr.sv
// rtl/sm_stack_ptr.sv - stack pointer, entry count, sticky error flags and write control
module sm_stack_ptr
  import sm_hw_stack_pkg::*;
#(
  parameter int DEPTH = SM_STACK_DEPTH,
  parameter int PTR_W = SM_STACK_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [PTR_W-1:0] sp,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             we,
  output logic [PTR_W-1:0] widx
);

  localparam logic [PTR_W-1:0] SP_RST   = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] SP_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  stk_act_e         act;
  logic [PTR_W-1:0] sp_inc;
  logic [PTR_W-1:0] sp_dec;
  logic [PTR_W-1:0] sp_chk;

  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign sp_inc = sp + SP_ONE;
  assign sp_dec = sp - SP_ONE;

  // Resolve the requested operation against the current fill level.
  always_comb begin
    act = stk_resolve(stk_decode(push, pop), full, empty);
  end

  // Array write port: push writes the free slot, replace rewrites the top.
  always_comb begin
    we   = 1'b0;
    widx = sp;
    if (!rst) begin
      case (act)
        STK_ACT_PUSH: begin
          we   = 1'b1;
          widx = sp;
        end
        STK_ACT_REPL: begin
          we   = 1'b1;
          widx = sp_inc;
        end
        default: begin
          we   = 1'b0;
          widx = sp;
        end
      endcase
    end
  end

  // Pointer/count update and sticky flags; a new error beats err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= SP_RST;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      case (act)
        STK_ACT_PUSH: begin
          sp    <= sp_dec;
          count <= count + CNT_ONE;
        end
        STK_ACT_POP: begin
          sp    <= sp_inc;
          count <= count - CNT_ONE;
        end
        STK_ACT_OVF:  overflow  <= 1'b1;
        STK_ACT_UNF:  underflow <= 1'b1;
        default: ;
      endcase
    end
  end

  // sp and count must always describe the same fill level.
  assign sp_chk = SP_RST - count[PTR_W-1:0];

  a_sp_count: assert property (@(posedge clk) disable iff (rst) (sp == sp_chk));

endmodule

// File: rtl/sm_hw_stack.sv
// rtl/sm_hw_stack.sv - downward-growing hardware LIFO with async-read storage and tos output
module sm_hw_stack
  import sm_hw_stack_pkg::*;
#(
  parameter int DATA_W = SM_STACK_DATA_W,
  parameter int DEPTH  = SM_STACK_DEPTH,
  parameter int PTR_W  = SM_STACK_PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  input  logic              err_clr,
  output logic [DATA_W-1:0] tos,
  output logic [PTR_W-1:0]  sp,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W-1:0] SP_ONE = PTR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;
  logic [PTR_W-1:0]  widx;
  logic [PTR_W-1:0]  top_idx;

  sm_stack_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .err_clr   (err_clr),
    .sp        (sp),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .we        (we),
    .widx      (widx)
  );

  // Storage is never cleared; the pointer block gates writes during reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Top entry sits one above the free slot; stale contents hidden when empty.
  assign top_idx = sp + SP_ONE;

  always_comb begin
    tos = '0;
    if (!empty) begin
      tos = mem[top_idx];
    end
  end

endmodule

// File: tb/tb_sm_hw_stack.sv
// tb/tb_sm_hw_stack.sv - scoreboard testbench for sm_hw_stack
module tb_sm_hw_stack;

  logic        clk;
  logic        rst;
  logic        push;
  logic        pop;
  logic [31:0] wdata;
  logic        err_clr;
  logic [31:0] tos;
  logic [4:0]  sp;
  logic [5:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  sm_hw_stack dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .err_clr   (err_clr),
    .tos       (tos),
    .sp        (sp),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic [31:0] tos;
    int          sp;
    int          cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    fails  = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input string field, input longint act,
                     input longint req);
    checks = checks + 1;
    if (act != req) begin
      fails = fails + 1;
      $display("FAIL %s %s got=%0h exp=%0h (cycle %0d)", nm, field, act, req, cyc);
    end
  endtask

  // Monitor: compares DUT state against the entry due this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.at < cyc) begin
        checks = checks + 1;
        fails  = fails + 1;
        $display("FAIL %s stale expectation at=%0d now=%0d", nm, e.at, cyc);
      end else begin
        chk(nm, "tos", longint'(tos), longint'(e.tos));
        chk(nm, "sp", longint'(sp), longint'(e.sp));
        chk(nm, "count", longint'(count), longint'(e.cnt));
        chk(nm, "empty", longint'(empty), longint'(e.cnt == 0));
        chk(nm, "full", longint'(full), longint'(e.cnt == 32));
        chk(nm, "overflow", longint'(overflow), longint'(e.ovf));
        chk(nm, "underflow", longint'(underflow), longint'(e.unf));
      end
    end
  end

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic step(input logic ps, input logic pp, input logic [31:0] wd,
                      input logic ec, input logic r, input logic [31:0] et,
                      input int esp, input int ecnt, input logic eo,
                      input logic eu, input string nm);
    exp_t e;
    push    = ps;
    pop     = pp;
    wdata   = wd;
    err_clr = ec;
    rst     = r;
    e.at  = cyc + 1;
    e.tos = et;
    e.sp  = esp;
    e.cnt = ecnt;
    e.ovf = eo;
    e.unf = eu;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    push = 0; pop = 0; wdata = 0; err_clr = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;

    // 1. reset values held through idle cycles
    step(0, 0, 0, 0, 0, 32'h0, 31, 0, 0, 0, "reset_idle0");
    step(0, 0, 0, 0, 0, 32'h0, 31, 0, 0, 0, "reset_idle1");
    step(0, 0, 0, 0, 0, 32'h0, 31, 0, 0, 0, "reset_idle2");

    // 2. three pushes, three pops
    step(1, 0, 32'hA, 0, 0, 32'hA, 30, 1, 0, 0, "push_a");
    step(1, 0, 32'hB, 0, 0, 32'hB, 29, 2, 0, 0, "push_b");
    step(1, 0, 32'hC, 0, 0, 32'hC, 28, 3, 0, 0, "push_c");
    step(0, 1, 0, 0, 0, 32'hB, 29, 2, 0, 0, "pop_c");
    step(0, 1, 0, 0, 0, 32'hA, 30, 1, 0, 0, "pop_b");
    step(0, 1, 0, 0, 0, 32'h0, 31, 0, 0, 0, "pop_a");

    // 3. fill to 32, overflow, clear, replace while full, drain
    for (int i = 0; i < 32; i++) begin
      step(1, 0, 32'(i + 1), 0, 0, 32'(i + 1), (30 - i) & 31, i + 1, 0, 0, "fill");
    end
    step(1, 0, 32'h99, 0, 0, 32'd32, 31, 32, 1, 0, "push_full_ovf");
    step(0, 0, 0, 0, 0, 32'd32, 31, 32, 1, 0, "ovf_sticky");
    step(0, 0, 0, 1, 0, 32'd32, 31, 32, 0, 0, "ovf_clear");
    step(1, 1, 32'h77, 0, 0, 32'h77, 31, 32, 0, 0, "replace_full");
    step(0, 1, 0, 0, 0, 32'd31, 0, 31, 0, 0, "drain_first");
    for (int k = 2; k <= 32; k++) begin
      step(0, 1, 0, 0, 0, 32'(32 - k), k - 1, 32 - k, 0, 0, "drain");
    end

    // 4. underflow, then push together with err_clr
    step(0, 1, 0, 0, 0, 32'h0, 31, 0, 0, 1, "pop_empty_unf");
    step(1, 0, 32'h5, 1, 0, 32'h5, 30, 1, 0, 0, "push_errclr");

    // 5. replace top, push+pop on empty acts as push
    step(1, 1, 32'h7, 0, 0, 32'h7, 30, 1, 0, 0, "replace_top");
    step(0, 1, 0, 0, 0, 32'h0, 31, 0, 0, 0, "pop_to_empty");
    step(1, 1, 32'h3C, 0, 0, 32'h3C, 30, 1, 0, 0, "pushpop_empty");
    step(0, 1, 0, 0, 0, 32'h0, 31, 0, 0, 0, "pop_to_empty2");
    step(0, 1, 0, 0, 0, 32'h0, 31, 0, 0, 1, "unf_again");
    step(0, 1, 0, 1, 0, 32'h0, 31, 0, 0, 1, "err_beats_clr");
    step(0, 0, 0, 1, 0, 32'h0, 31, 0, 0, 0, "unf_clear");

    // 6. reset wins over a push in the same cycle
    step(1, 0, 32'h11, 0, 0, 32'h11, 30, 1, 0, 0, "pre_rst_push1");
    step(1, 0, 32'h22, 0, 0, 32'h22, 29, 2, 0, 0, "pre_rst_push2");
    step(1, 0, 32'h33, 0, 1, 32'h0, 31, 0, 0, 0, "rst_with_push");
    step(0, 0, 0, 0, 0, 32'h0, 31, 0, 0, 0, "post_rst_idle");
    step(1, 0, 32'h44, 0, 0, 32'h44, 30, 1, 0, 0, "post_rst_push");

    push = 0; pop = 0; err_clr = 0; rst = 0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks = checks + 1;
      fails  = fails + 1;
      $display("FAIL drain_queue pending=%0d required=0", exp_q.size());
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
